// File: rtl/inference_seq_pkg.sv
// Shared types and constants for the inference host sequencer.
//   state_e   : sequencer FSM states
//   cmd_op_e  : host command opcodes
//   ERR_*     : error codes reported on err_code
//   WORD_W    : width of weight/input/result words
package inference_seq_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    W_START,
    W_SEND,
    W_WAIT,
    I_SEND,
    I_WAIT,
    RUN,
    ERROR
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD_WEIGHTS = 2'b00,
    OP_RUN          = 2'b01,
    OP_CLEAR_ERR    = 2'b10,
    OP_NOP          = 2'b11
  } cmd_op_e;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_OCCUPANCY  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b10;
  localparam logic [1:0] ERR_NO_WEIGHTS = 2'b11;

endpackage

// File: rtl/seq_timeout_counter.sv
// Wait-state watchdog for the inference host sequencer.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart the count from zero (takes priority over enable)
//   enable   : count one cycle spent waiting
//   expired  : high in the enabled cycle in which the count reaches
//              TIMEOUT_CYCLES, so the owner leaves after exactly
//              TIMEOUT_CYCLES waiting cycles
module seq_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired = enable && !clear && (cnt_d == LIMIT);

  // NOTE: state flops use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/inference_host_sequencer.sv
// Initiator-side sequencer for the systolic-array peripheral.
// Accepts host commands (load weights / run inference / clear error),
// streams source words into the peripheral one strobe at a time, waits for
// the peripheral's completion flags and returns output_reg on a result stream.
//   cmd_*            : host command channel (cmd_ready is combinational)
//   cfg_bias/mode    : run configuration, latched when a run is accepted
//   src_*            : upstream weight/input word stream (src_ready pops)
//   load_*/start_*   : registered command pulses and word strobes to the peripheral
//   weight/input_reg : word presented with its strobe
//   controller_busy, data_ready, weights_done, inputs_done, occupancy_err,
//   output_reg       : peripheral status and result
//   res_*            : result stream, held until res_ready
//   busy, err, err_code, weights_loaded : status back to the register block
module inference_host_sequencer
  import inference_seq_pkg::*;
#(
  parameter int NUM_WEIGHT_WORDS = 8,
  parameter int NUM_INPUT_WORDS  = 8,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  input  logic [WORD_W-1:0] cfg_bias,
  input  logic [1:0]        cfg_mode,
  input  logic              src_valid,
  input  logic [WORD_W-1:0] src_data,
  output logic              src_ready,
  output logic              load_weights,
  output logic              start_inference,
  output logic              load_weights_en,
  output logic              load_inputs_en,
  output logic [WORD_W-1:0] weight_reg,
  output logic [WORD_W-1:0] input_reg,
  output logic [WORD_W-1:0] bias_vec,
  output logic [1:0]        activation_mode,
  input  logic              controller_busy,
  input  logic              data_ready,
  input  logic              weights_done,
  input  logic              inputs_done,
  input  logic              occupancy_err,
  input  logic [WORD_W-1:0] output_reg,
  output logic              res_valid,
  output logic [WORD_W-1:0] res_data,
  input  logic              res_ready,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              weights_loaded
);

  localparam int MAX_WORDS = (NUM_WEIGHT_WORDS > NUM_INPUT_WORDS) ? NUM_WEIGHT_WORDS : NUM_INPUT_WORDS;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_W = CNT_W'(NUM_WEIGHT_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_I = CNT_W'(NUM_INPUT_WORDS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              weights_loaded_q, weights_loaded_d;
  logic              res_valid_q, res_valid_d;
  logic [WORD_W-1:0] res_data_q, res_data_d;
  logic              load_weights_q, load_weights_d;
  logic              start_inference_q, start_inference_d;
  logic              load_weights_en_q, load_weights_en_d;
  logic              load_inputs_en_q, load_inputs_en_d;
  logic [WORD_W-1:0] weight_reg_q, weight_reg_d;
  logic [WORD_W-1:0] input_reg_q, input_reg_d;
  logic [WORD_W-1:0] bias_vec_q, bias_vec_d;
  logic [1:0]        activation_mode_q, activation_mode_d;

  cmd_op_e    op;
  logic       cmd_fire;
  logic       send_state, strobe_pending, last_word, pop;
  logic       set_err;
  logic [1:0] new_err_code;
  logic       tmo_clear, tmo_enable, tmo_expired;

  assign op       = cmd_op_e'(cmd_op);
  // In ERROR only the clear opcode is let through; everything else is held off.
  assign cmd_ready = !rst && (((state_q == IDLE) && !res_valid_q) ||
                              ((state_q == ERROR) && (op == OP_CLEAR_ERR)));
  assign cmd_fire = cmd_valid && cmd_ready;

  assign send_state     = (state_q == W_SEND) || (state_q == I_SEND);
  // A strobe is on the pins this cycle; the next pop waits a cycle, giving
  // the peripheral one word per two cycles at most.
  assign strobe_pending = load_weights_en_q || load_inputs_en_q;
  assign last_word      = (word_cnt_q == ((state_q == W_SEND) ? LAST_W : LAST_I));
  // No pop while an occupancy error is aborting the stream, so no orphan strobe.
  assign src_ready      = send_state && src_valid && !controller_busy &&
                          !strobe_pending && !occupancy_err;
  assign pop            = src_ready;

  // Restart the watchdog on each transition into a wait state; decoded from
  // the transition conditions rather than state_d to avoid a loop through expired.
  assign tmo_clear  = (send_state && strobe_pending && last_word) ||
                      ((state_q == I_WAIT) && inputs_done);
  assign tmo_enable = (state_q == W_WAIT) || (state_q == I_WAIT) || (state_q == RUN);

  seq_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  // Next-state logic. Occupancy errors override every other decision.
  always_comb begin
    state_d      = state_q;
    set_err      = 1'b0;
    new_err_code = ERR_NONE;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          unique case (op)
            OP_LOAD_WEIGHTS: state_d = W_START;
            OP_RUN: begin
              if (weights_loaded_q) begin
                state_d = I_SEND;
              end else begin
                state_d      = ERROR;
                set_err      = 1'b1;
                new_err_code = ERR_NO_WEIGHTS;
              end
            end
            OP_CLEAR_ERR, OP_NOP: state_d = IDLE;
          endcase
        end
      end
      W_START: state_d = W_SEND;
      W_SEND, I_SEND: begin
        if (strobe_pending && last_word) state_d = (state_q == W_SEND) ? W_WAIT : I_WAIT;
      end
      W_WAIT, I_WAIT, RUN: begin
        if ((state_q == W_WAIT && weights_done) || (state_q == RUN && data_ready)) begin
          state_d = IDLE;
        end else if (state_q == I_WAIT && inputs_done) begin
          state_d = RUN;
        end else if (tmo_expired) begin
          state_d      = ERROR;
          set_err      = 1'b1;
          new_err_code = ERR_TIMEOUT;
        end
      end
      ERROR: begin
        if (cmd_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (occupancy_err && (state_q != IDLE) && (state_q != ERROR)) begin
      state_d      = ERROR;
      set_err      = 1'b1;
      new_err_code = ERR_OCCUPANCY;
    end
  end

  // Output and datapath next values.
  always_comb begin
    word_cnt_d        = word_cnt_q;
    err_d             = err_q;
    err_code_d        = err_code_q;
    weights_loaded_d  = weights_loaded_q;
    res_valid_d       = res_valid_q;
    res_data_d        = res_data_q;
    weight_reg_d      = weight_reg_q;
    input_reg_d       = input_reg_q;
    bias_vec_d        = bias_vec_q;
    activation_mode_d = activation_mode_q;

    load_weights_d    = (state_d == W_START);
    start_inference_d = (state_q == I_WAIT) && (state_d == RUN);
    load_weights_en_d = pop && (state_q == W_SEND);
    load_inputs_en_d  = pop && (state_q == I_SEND);

    if (pop && (state_q == W_SEND)) weight_reg_d = src_data;
    if (pop && (state_q == I_SEND)) input_reg_d  = src_data;

    if (!send_state) begin
      word_cnt_d = '0;
    end else if (strobe_pending) begin
      word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
    end

    if (cmd_fire && (state_q == IDLE) && (op == OP_RUN)) begin
      bias_vec_d        = cfg_bias;
      activation_mode_d = cfg_mode;
    end

    if ((state_q == W_WAIT) && (state_d == IDLE)) weights_loaded_d = 1'b1;

    if (res_valid_q && res_ready) res_valid_d = 1'b0;
    if ((state_q == RUN) && (state_d == IDLE)) begin
      res_valid_d = 1'b1;
      res_data_d  = output_reg;
    end

    // Only the first error is recorded until the host clears it.
    if ((state_q == ERROR) && (state_d == IDLE)) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end else if (set_err && !err_q) begin
      err_d      = 1'b1;
      err_code_d = new_err_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: datapath registers are reset too, since every output must read 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q        <= '0;
      err_q             <= 1'b0;
      err_code_q        <= ERR_NONE;
      weights_loaded_q  <= 1'b0;
      res_valid_q       <= 1'b0;
      res_data_q        <= '0;
      load_weights_q    <= 1'b0;
      start_inference_q <= 1'b0;
      load_weights_en_q <= 1'b0;
      load_inputs_en_q  <= 1'b0;
      weight_reg_q      <= '0;
      input_reg_q       <= '0;
      bias_vec_q        <= '0;
      activation_mode_q <= 2'b00;
    end else begin
      word_cnt_q        <= word_cnt_d;
      err_q             <= err_d;
      err_code_q        <= err_code_d;
      weights_loaded_q  <= weights_loaded_d;
      res_valid_q       <= res_valid_d;
      res_data_q        <= res_data_d;
      load_weights_q    <= load_weights_d;
      start_inference_q <= start_inference_d;
      load_weights_en_q <= load_weights_en_d;
      load_inputs_en_q  <= load_inputs_en_d;
      weight_reg_q      <= weight_reg_d;
      input_reg_q       <= input_reg_d;
      bias_vec_q        <= bias_vec_d;
      activation_mode_q <= activation_mode_d;
    end
  end

  assign load_weights    = load_weights_q;
  assign start_inference = start_inference_q;
  assign load_weights_en = load_weights_en_q;
  assign load_inputs_en  = load_inputs_en_q;
  assign weight_reg      = weight_reg_q;
  assign input_reg       = input_reg_q;
  assign bias_vec        = bias_vec_q;
  assign activation_mode = activation_mode_q;
  assign res_valid       = res_valid_q;
  assign res_data        = res_data_q;
  assign busy            = (state_q != IDLE);
  assign err             = err_q;
  assign err_code        = err_code_q;
  assign weights_loaded  = weights_loaded_q;

endmodule

// File: tb/tb_inference_host_sequencer.sv
// Scoreboard bench for inference_host_sequencer: stimulus pushes expected
// words/results into queues, a negedge monitor pops and compares whenever
// the DUT strobes a word or hands over a result.
module tb_inference_host_sequencer;

  localparam int NW  = 8;
  localparam int NI  = 8;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [63:0] cfg_bias;
  logic [1:0]  cfg_mode;
  logic        src_valid, src_ready;
  logic [63:0] src_data;
  logic        load_weights, start_inference, load_weights_en, load_inputs_en;
  logic [63:0] weight_reg, input_reg, bias_vec;
  logic [1:0]  activation_mode;
  logic        controller_busy, data_ready, weights_done, inputs_done, occupancy_err;
  logic [63:0] output_reg;
  logic        res_valid, res_ready;
  logic [63:0] res_data;
  logic        busy, err, weights_loaded;
  logic [1:0]  err_code;

  int checks = 0, errors = 0, cyc = 0;
  int wstrobe_cnt = 0, istrobe_cnt = 0, lw_pulse_cnt = 0, si_pulse_cnt = 0, res_hs_cnt = 0;
  int si_cyc = 0, err_cyc = 0, last_w_cyc = 0, gap_bad = 0;
  int pops_while_busy = 0, strobe_while_busy = 0;
  bit check_gap = 1'b0, src_toggle = 1'b0;
  logic busy_prev = 1'b0, err_prev = 1'b0;
  logic [63:0] src_q[$], exp_w_q[$], exp_i_q[$], exp_res_q[$];

  inference_host_sequencer #(
    .NUM_WEIGHT_WORDS(NW), .NUM_INPUT_WORDS(NI), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .cfg_bias(cfg_bias), .cfg_mode(cfg_mode),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .load_weights(load_weights), .start_inference(start_inference),
    .load_weights_en(load_weights_en), .load_inputs_en(load_inputs_en),
    .weight_reg(weight_reg), .input_reg(input_reg),
    .bias_vec(bias_vec), .activation_mode(activation_mode),
    .controller_busy(controller_busy), .data_ready(data_ready),
    .weights_done(weights_done), .inputs_done(inputs_done),
    .occupancy_err(occupancy_err), .output_reg(output_reg),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .err(err), .err_code(err_code), .weights_loaded(weights_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (load_weights) lw_pulse_cnt++;
      if (start_inference) begin
        si_pulse_cnt++;
        si_cyc = cyc;
      end
      if (load_weights_en) begin
        if (check_gap && wstrobe_cnt > 0 && (cyc - last_w_cyc) != 2) gap_bad++;
        last_w_cyc = cyc;
        wstrobe_cnt++;
        if (exp_w_q.size() == 0) fail_now("weight_strobe_unexpected");
        else check("weight_word", weight_reg, exp_w_q.pop_front());
      end
      if (load_inputs_en) begin
        istrobe_cnt++;
        if (controller_busy && busy_prev) strobe_while_busy++;
        if (exp_i_q.size() == 0) fail_now("input_strobe_unexpected");
        else check("input_word", input_reg, exp_i_q.pop_front());
      end
      if (src_valid && src_ready && controller_busy) pops_while_busy++;
      if (res_valid && res_ready) begin
        res_hs_cnt++;
        if (exp_res_q.size() == 0) fail_now("result_unexpected");
        else check("res_data", res_data, exp_res_q.pop_front());
      end
      if (err && !err_prev) err_cyc = cyc;
    end
    busy_prev = controller_busy;
    err_prev  = err;
  end

  // Upstream word source.
  initial begin : src_driver
    bit fire;
    bit phase;
    phase     = 1'b0;
    src_valid = 1'b0;
    src_data  = 64'h0;
    forever begin
      @(negedge clk);
      fire = src_valid && src_ready;
      @(posedge clk);
      #1;
      if (fire && src_q.size() > 0) void'(src_q.pop_front());
      phase     = ~phase;
      src_valid = (src_q.size() > 0) && (!src_toggle || phase);
      src_data  = (src_q.size() > 0) ? src_q[0] : 64'h0;
    end
  end

  function automatic int get_count(input int which);
    case (which)
      0:       return wstrobe_cnt;
      1:       return istrobe_cnt;
      2:       return si_pulse_cnt;
      3:       return int'(res_valid);
      4:       return int'(err);
      default: return res_hs_cnt;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_count(input int which, input int target, input string name);
    int n = 0;
    while (get_count(which) < target) begin
      sample();
      n++;
      if (n > 400) begin
        fail_now(name);
        break;
      end
    end
  endtask

  task automatic issue_cmd(input logic [1:0] op);
    int n = 0;
    step(1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 50) begin
        fail_now("cmd_accept");
        break;
      end
    end
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    step(1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    src_q.delete();
    exp_w_q.delete();
    exp_i_q.delete();
    exp_res_q.delete();
    step(1);
  endtask

  // Weight load; weights_done (optionally with occupancy_err) 3 cycles after the last strobe.
  task automatic do_weight_load(input logic [63:0] base, input bit occ);
    int n0 = wstrobe_cnt;
    for (int i = 0; i < NW; i++) begin
      src_q.push_back(base + 64'(i));
      exp_w_q.push_back(base + 64'(i));
    end
    issue_cmd(2'b00);
    wait_count(0, n0 + NW, "weight_strobes");
    step(3);
    weights_done  = 1'b1;
    occupancy_err = occ;
    step(1);
    weights_done  = 1'b0;
    occupancy_err = 1'b0;
    sample();
  endtask

  // Run command plus all input words; returns after the last input strobe.
  task automatic run_inputs(input logic [63:0] base);
    int n0 = istrobe_cnt;
    for (int i = 0; i < NI; i++) begin
      src_q.push_back(base + 64'(i));
      exp_i_q.push_back(base + 64'(i));
    end
    issue_cmd(2'b01);
    wait_count(1, n0 + NI, "input_strobes");
  endtask

  task automatic pulse_inputs_done();
    step(2);
    inputs_done = 1'b1;
    step(1);
    inputs_done = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cfg_bias = 64'h0; cfg_mode = 2'b00;
    controller_busy = 1'b0; data_ready = 1'b0; weights_done = 1'b0;
    inputs_done = 1'b0; occupancy_err = 1'b0; output_reg = 64'h0; res_ready = 1'b0;
    step(3);
    rst = 1'b0;
    sample();

    // Reset state.
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset_flags", 64'({busy, err, err_code, weights_loaded, res_valid, src_ready}), 64'd0);

    // Run before weights are loaded.
    issue_cmd(2'b01);
    sample();
    check("nowt_err", 64'(err), 64'd1);
    check("nowt_code", 64'(err_code), 64'd3);
    check("nowt_busy", 64'(busy), 64'd1);
    check("nowt_pulses", 64'(si_pulse_cnt + lw_pulse_cnt), 64'd0);
    step(1);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    sample();
    check("err_holdoff_cmd_ready", 64'(cmd_ready), 64'd0);
    issue_cmd(2'b10);
    sample();
    check("clear_err", 64'({err, err_code, busy}), 64'd0);
    check("clear_cmd_ready", 64'(cmd_ready), 64'd1);

    // Weight load with continuous source.
    check_gap = 1'b1;
    do_weight_load(64'h1, 1'b0);
    check_gap = 1'b0;
    check("wl_loaded", 64'(weights_loaded), 64'd1);
    check("wl_idle", 64'(busy), 64'd0);
    check("wl_pulses", 64'(lw_pulse_cnt), 64'd1);
    check("wl_strobes", 64'(wstrobe_cnt), 64'd8);
    check("wl_gap_violations", 64'(gap_bad), 64'd0);

    // Full inference with result backpressure.
    cfg_bias = 64'hAAAA_AAAA_AAAA_AAAA;
    cfg_mode = 2'd2;
    n0 = si_pulse_cnt;
    run_inputs(64'h100);
    cfg_bias = 64'h5555_5555_5555_5555;
    cfg_mode = 2'd1;
    pulse_inputs_done();
    wait_count(2, n0 + 1, "start_inference");
    step(3);
    output_reg = 64'h0000_0000_DEAD_BEEF;
    data_ready = 1'b1;
    exp_res_q.push_back(64'h0000_0000_DEAD_BEEF);
    step(1);
    data_ready = 1'b0;
    output_reg = 64'h0;
    wait_count(3, 1, "res_valid");
    for (int i = 0; i < 5; i++) begin
      sample();
      check("res_hold_valid", 64'(res_valid), 64'd1);
      check("res_hold_data", res_data, 64'h0000_0000_DEAD_BEEF);
      check("res_hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    step(1);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    sample();
    check("res_consumed", 64'(res_valid), 64'd0);
    check("res_cmd_ready", 64'(cmd_ready), 64'd1);
    check("res_handshakes", 64'(res_hs_cnt), 64'd1);
    check("run_pulses", 64'(si_pulse_cnt - n0), 64'd1);
    check("bias_latched", bias_vec, 64'hAAAA_AAAA_AAAA_AAAA);
    check("mode_latched", 64'(activation_mode), 64'd2);

    // Peripheral backpressure with a toggling source.
    src_toggle = 1'b1;
    n0 = istrobe_cnt;
    for (int i = 0; i < NI; i++) begin
      src_q.push_back(64'h200 + 64'(i));
      exp_i_q.push_back(64'h200 + 64'(i));
    end
    issue_cmd(2'b01);
    wait_count(1, n0 + 3, "bp_first_strobes");
    step(1);
    controller_busy = 1'b1;
    step(10);
    controller_busy = 1'b0;
    wait_count(1, n0 + NI, "bp_all_strobes");
    step(3);
    src_toggle = 1'b0;
    check("bp_total_strobes", 64'(istrobe_cnt - n0), 64'd8);
    check("bp_words_left", 64'(exp_i_q.size()), 64'd0);
    check("bp_pops_while_busy", 64'(pops_while_busy), 64'd0);
    check("bp_strobes_while_busy", 64'(strobe_while_busy), 64'd0);
    inputs_done = 1'b1;
    step(1);
    inputs_done = 1'b0;
    step(2);
    res_ready  = 1'b1;
    output_reg = 64'h0123_4567_89AB_CDEF;
    data_ready = 1'b1;
    exp_res_q.push_back(64'h0123_4567_89AB_CDEF);
    step(1);
    data_ready = 1'b0;
    wait_count(5, 2, "bp_result");
    step(1);
    res_ready = 1'b0;

    // Timeout in RUN.
    run_inputs(64'h300);
    pulse_inputs_done();
    wait_count(4, 1, "timeout_err");
    check("timeout_latency", 64'(err_cyc - si_cyc), 64'd16);
    check("timeout_code", 64'(err_code), 64'd2);
    check("timeout_no_result", 64'(res_valid), 64'd0);
    issue_cmd(2'b10);
    sample();
    check("timeout_cleared", 64'({err, busy}), 64'd0);

    // Occupancy error beats weights_done in the same cycle.
    do_reset();
    do_weight_load(64'h40, 1'b1);
    check("occ_err", 64'(err), 64'd1);
    check("occ_code", 64'(err_code), 64'd1);
    check("occ_not_loaded", 64'(weights_loaded), 64'd0);
    issue_cmd(2'b10);
    sample();
    check("occ_cleared", 64'({err, busy, weights_loaded}), 64'd0);

    // Reset in the middle of an input stream.
    do_weight_load(64'h50, 1'b0);
    check("rs_loaded", 64'(weights_loaded), 64'd1);
    cfg_bias = 64'hFEED_0000_0000_0001;
    n0 = istrobe_cnt;
    for (int i = 0; i < NI; i++) begin
      src_q.push_back(64'h600 + 64'(i));
      exp_i_q.push_back(64'h600 + 64'(i));
    end
    issue_cmd(2'b01);
    wait_count(1, n0 + 3, "rs_strobes");
    #2;
    rst = 1'b1;
    #1;
    check("rs_async_flags", 64'({load_weights, start_inference, load_weights_en, load_inputs_en,
                                 activation_mode, busy, err, err_code, weights_loaded,
                                 res_valid, src_ready, cmd_ready}), 64'd0);
    check("rs_async_words", weight_reg | input_reg | bias_vec | res_data, 64'd0);
    step(2);
    rst = 1'b0;
    src_q.delete();
    exp_i_q.delete();
    sample();
    check("rs_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rs_weights_loaded", 64'(weights_loaded), 64'd0);
    check("rs_busy", 64'(busy), 64'd0);
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
